// File: rtl/spi_adc_responder.sv
// Avalon-ST command/response front end for an LTC2308-style 8-channel SPI ADC.
// Each frame configures the next conversion while reading back the previous one.
module spi_adc_responder #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [4:0]  cmd_channel,
    input  logic        cmd_sop,
    input  logic        cmd_eop,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [4:0]  rsp_channel,
    output logic [11:0] rsp_data,
    output logic        rsp_sop,
    output logic        rsp_eop,
    output logic        cmd_err,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);
    localparam int CONV_W = $clog2(CONV_CYCLES + 1);
    localparam int PH_W   = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [CONV_W-1:0] conv_cnt;
    logic [PH_W-1:0]   ph_cnt;
    logic [3:0]        bit_cnt;
    logic [2:0]        ch, prev_ch;
    logic              prev_valid;
    logic [11:0]       cfg_sr, sdo_sr, sdo_nxt;
    logic              sck_q;
    logic              cmd_legal, conv_last, ph_last, sample_now, shift_last;
    logic              unused_inputs;

    assign unused_inputs = cmd_sop ^ cmd_eop;

    assign cmd_legal  = (cmd_channel >= 5'd1) && (cmd_channel <= 5'd8);
    assign conv_last  = (conv_cnt == CONV_W'(CONV_CYCLES - 1));
    assign ph_last    = (ph_cnt == PH_W'(CLK_DIV - 1));
    // Capture SDO in the first cycle SCK is high; the ADC updates it on the falling edge.
    assign sample_now = sck_q && (ph_cnt == '0);
    assign shift_last = sck_q && ph_last && (bit_cnt == 4'd11);
    assign sdo_nxt    = sample_now ? {sdo_sr[10:0], adc_sdo} : sdo_sr;

    assign adc_sck  = sck_q;
    assign adc_sdi  = cfg_sr[11];
    assign rsp_sop  = rsp_valid;
    assign rsp_eop  = rsp_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && cmd_legal) state_nxt = CONV;
            end
            CONV:    if (conv_last)  state_nxt = SHIFT;
            SHIFT:   if (shift_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conv_cnt    <= '0;
            ph_cnt      <= '0;
            bit_cnt     <= '0;
            ch          <= '0;
            prev_ch     <= '0;
            prev_valid  <= 1'b0;
            cfg_sr      <= '0;
            sdo_sr      <= '0;
            sck_q       <= 1'b0;
            adc_convst  <= 1'b0;
            cmd_err     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_channel <= '0;
            rsp_data    <= '0;
        end else begin
            cmd_err   <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_legal) begin
                            ch         <= cmd_channel[2:0] - 3'd1;
                            conv_cnt   <= '0;
                            adc_convst <= 1'b1;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    conv_cnt <= conv_cnt + CONV_W'(1);
                    if (conv_cnt == CONV_W'(1)) adc_convst <= 1'b0;
                    if (conv_last) begin
                        ph_cnt  <= '0;
                        bit_cnt <= '0;
                        sck_q   <= 1'b0;
                        // S/D, O/S, S1, S0, UNI, SLP followed by six zero bits
                        cfg_sr  <= {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0, 6'b0};
                    end
                end
                SHIFT: begin
                    sdo_sr <= sdo_nxt;
                    if (ph_last) begin
                        ph_cnt <= '0;
                        sck_q  <= ~sck_q;
                        if (sck_q) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            cfg_sr  <= {cfg_sr[10:0], 1'b0};
                        end
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                    // The word read now belongs to the conversion set up by the previous frame.
                    if (shift_last && prev_valid) begin
                        rsp_valid   <= 1'b1;
                        rsp_channel <= {2'b00, prev_ch} + 5'd1;
                        rsp_data    <= sdo_nxt;
                    end
                end
                DONE: begin
                    prev_ch    <= ch;
                    prev_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: two instances (CLK_DIV 2 and 5), behavioural ADC model,
// response scoreboard and SCK/SDI timing monitors.
module tb_spi_adc_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  cmd_valid, cmd_ready, rsp_valid, rsp_sop, rsp_eop, cmd_err;
    logic [1:0]  convst, sck, sdi, sdo;
    logic        cmd_sop, cmd_eop;
    logic [4:0]  cmd_channel [2];
    logic [4:0]  rsp_channel [2];
    logic [11:0] rsp_data [2];

    logic [11:0] val [2][8];
    logic        pv [2];
    logic [4:0]  pch [2];
    logic [4:0]  cur_ch [2];
    int          nrise [2];
    logic [17:0] sb [$];
    int          tests = 0;
    int          fails = 0;

    spi_adc_responder #(.CLK_DIV(2), .CONV_CYCLES(80)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[0]), .cmd_channel(cmd_channel[0]),
        .cmd_sop(cmd_sop), .cmd_eop(cmd_eop), .cmd_ready(cmd_ready[0]), .rsp_valid(rsp_valid[0]),
        .rsp_channel(rsp_channel[0]), .rsp_data(rsp_data[0]), .rsp_sop(rsp_sop[0]), .rsp_eop(rsp_eop[0]),
        .cmd_err(cmd_err[0]), .adc_convst(convst[0]), .adc_sck(sck[0]), .adc_sdi(sdi[0]), .adc_sdo(sdo[0]));

    spi_adc_responder #(.CLK_DIV(5), .CONV_CYCLES(80)) dut5 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[1]), .cmd_channel(cmd_channel[1]),
        .cmd_sop(cmd_sop), .cmd_eop(cmd_eop), .cmd_ready(cmd_ready[1]), .rsp_valid(rsp_valid[1]),
        .rsp_channel(rsp_channel[1]), .rsp_data(rsp_data[1]), .rsp_sop(rsp_sop[1]), .rsp_eop(rsp_eop[1]),
        .cmd_err(cmd_err[1]), .adc_convst(convst[1]), .adc_sck(sck[1]), .adc_sdi(sdi[1]), .adc_sdo(sdo[1]));

    // ADC model plus pin-timing and response checks for instance g, sampled on falling clk.
    task automatic monitor(input int g);
        int d, nfall, hi_run, lo_run;
        logic [11:0] word;
        logic [5:0] cfg_sh, cfg_last;
        logic psck, psdi, pcv;
        logic [17:0] e;
        logic [2:0] c;
        d = (g == 0) ? 2 : 5;
        nfall = 0; hi_run = 0; lo_run = 0;
        word = '0; cfg_sh = '0; cfg_last = '0;
        psck = 1'b0; psdi = 1'b0; pcv = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                psck = 1'b0; psdi = 1'b0; pcv = 1'b0; sdo[g] = 1'b0;
                continue;
            end
            if (convst[g] && !pcv) begin
                word = val[g][{cfg_last[3], cfg_last[2], cfg_last[4]}];
                nrise[g] = 0; nfall = 0; sdo[g] = word[11];
            end
            if (sck[g] && !psck) begin
                if (nrise[g] > 0) begin
                    tests++;
                    if (lo_run != d) begin
                        fails++; $display("FAIL sck_low[%0d]: got %0d cycles, want %0d", g, lo_run, d);
                    end
                end
                if (nrise[g] < 6) cfg_sh = {cfg_sh[4:0], sdi[g]};
                else begin
                    tests++;
                    if (sdi[g] !== 1'b0) begin
                        fails++; $display("FAIL sdi_pad[%0d]: bit %0d got %b, want 0", g, nrise[g], sdi[g]);
                    end
                end
                if (nrise[g] == 5) begin
                    c = cur_ch[g][2:0] - 3'd1;
                    tests++;
                    if (cfg_sh !== {1'b1, c[0], c[2], c[1], 1'b1, 1'b0}) begin
                        fails++;
                        $display("FAIL sdi_cfg[%0d]: got %b, want %b", g, cfg_sh, {1'b1, c[0], c[2], c[1], 1'b1, 1'b0});
                    end
                    cfg_last = cfg_sh;
                end
                nrise[g]++;
                hi_run = 0;
            end
            if (!sck[g] && psck) begin
                tests++;
                if (hi_run != d) begin
                    fails++; $display("FAIL sck_high[%0d]: got %0d cycles, want %0d", g, hi_run, d);
                end
                nfall++;
                sdo[g] = (nfall < 12) ? word[11 - nfall] : 1'b0;
                lo_run = 0;
            end
            if (sck[g]) begin
                hi_run++;
                tests++;
                if (sdi[g] !== psdi) begin
                    fails++; $display("FAIL sdi_stable[%0d]: got %b while sck high, want %b", g, sdi[g], psdi);
                end
            end else begin
                lo_run++;
            end
            psck = sck[g]; psdi = sdi[g]; pcv = convst[g];

            tests++;
            if (rsp_sop[g] !== rsp_valid[g] || rsp_eop[g] !== rsp_valid[g]) begin
                fails++;
                $display("FAIL sop_eop[%0d]: got sop=%b eop=%b, want %b", g, rsp_sop[g], rsp_eop[g], rsp_valid[g]);
            end
            if (rsp_valid[g] === 1'b1) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected[%0d]: got ch=%0d data=%h, want none", g, rsp_channel[g], rsp_data[g]);
                end else begin
                    e = sb.pop_front();
                    if ({1'(g), rsp_channel[g], rsp_data[g]} !== e) begin
                        fails++;
                        $display("FAIL rsp[%0d]: got ch=%0d data=%h, want inst=%0d ch=%0d data=%h",
                                 g, rsp_channel[g], rsp_data[g], e[17], e[16:12], e[11:0]);
                    end
                end
            end
        end
    endtask

    // Issue one command at a falling edge; returns at the falling edge where cmd_ready is back.
    task automatic send(input int g, input logic [4:0] ch);
        int k, rk, done_k;
        logic legal, expect_rsp;
        done_k = 80 + 24 * ((g == 0) ? 2 : 5) + 1;
        cmd_channel[g] = ch;
        cmd_valid[g] = 1'b1;
        cmd_sop = 1'($urandom_range(0, 1));
        cmd_eop = 1'($urandom_range(0, 1));
        k = 0;
        while (cmd_ready[g] !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        tests++;
        if (cmd_ready[g] !== 1'b1) begin
            fails++; $display("FAIL ready_timeout[%0d]: got cmd_ready=%b, want 1", g, cmd_ready[g]);
        end
        legal = (ch >= 5'd1) && (ch <= 5'd8);
        expect_rsp = legal && pv[g];
        if (legal) begin
            if (pv[g]) sb.push_back({1'(g), pch[g], val[g][pch[g][2:0] - 3'd1]});
            pv[g] = 1'b1; pch[g] = ch; cur_ch[g] = ch;
        end
        @(negedge clk);
        cmd_valid[g] = 1'b0;
        if (!legal) return;
        k = 1; rk = 0;
        while (cmd_ready[g] !== 1'b1 && k < 1000) begin
            if (rsp_valid[g] === 1'b1 && rk == 0) rk = k;
            @(negedge clk); k++;
        end
        tests++;
        if (k != done_k + 1) begin
            fails++; $display("FAIL busy[%0d]: ready back at T+%0d, want T+%0d", g, k, done_k + 1);
        end
        tests++;
        if (rk != (expect_rsp ? done_k : 0)) begin
            fails++; $display("FAIL rsp_time[%0d]: got T+%0d, want T+%0d (0 = none)", g, rk, expect_rsp ? done_k : 0);
        end
        tests++;
        if (nrise[g] != 12) begin
            fails++; $display("FAIL sck_rises[%0d]: got %0d, want 12", g, nrise[g]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            tests++;
            if ({rsp_valid[g], rsp_sop[g], rsp_eop[g], cmd_err[g], convst[g], sck[g], sdi[g]} !== 7'b0 ||
                rsp_channel[g] !== 5'd0 || rsp_data[g] !== 12'd0) begin
                fails++;
                $display("FAIL reset_vals[%0d]: got v=%b ch=%0d d=%h err=%b cv=%b sck=%b sdi=%b, want all 0",
                         g, rsp_valid[g], rsp_channel[g], rsp_data[g], cmd_err[g], convst[g], sck[g], sdi[g]);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            tests++;
            if ({cmd_ready[0], convst[0], sck[0], sdi[0], rsp_valid[0]} !== 5'b10000) begin
                fails++;
                $display("FAIL idle: got rdy/cv/sck/sdi/rsp=%b, want 10000",
                         {cmd_ready[0], convst[0], sck[0], sdi[0], rsp_valid[0]});
            end
        end
    endtask

    task automatic test_pipeline();
        val[0][0] = 12'hABC;
        send(0, 5'd1);
        send(0, 5'd3);
        tests++;
        if (rsp_valid[0] !== 1'b0 || rsp_channel[0] !== 5'd1 || rsp_data[0] !== 12'hABC) begin
            fails++;
            $display("FAIL rsp_hold: got v=%b ch=%0d d=%h, want v=0 ch=1 d=abc", rsp_valid[0], rsp_channel[0], rsp_data[0]);
        end
    endtask

    task automatic test_continuous();
        int k, last_acc;
        logic [4:0] ch;
        last_acc = 0;
        for (int c = 0; c < 8; c++) val[0][c] = 12'($urandom);
        cmd_valid[0] = 1'b1;
        for (int f = 0; f < 100; f++) begin
            ch = 5'((f % 8) + 1);
            cmd_channel[0] = ch;
            k = 0;
            while (cmd_ready[0] !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
            tests++;
            if (cmd_ready[0] !== 1'b1) begin
                fails++; $display("FAIL cont_timeout: frame %0d got cmd_ready=%b, want 1", f, cmd_ready[0]);
            end
            if (pv[0]) sb.push_back({1'b0, pch[0], val[0][pch[0][2:0] - 3'd1]});
            pv[0] = 1'b1; pch[0] = ch; cur_ch[0] = ch;
            if (f > 0) begin
                tests++;
                if (cyc - last_acc != 130) begin
                    fails++; $display("FAIL period: frame %0d got %0d cycles, want 130", f, cyc - last_acc);
                end
            end
            last_acc = cyc;
            @(negedge clk);
        end
        cmd_valid[0] = 1'b0;
        k = 0;
        while ((sb.size() != 0 || cmd_ready[0] !== 1'b1) && k < 1000) begin @(negedge clk); k++; end
        tests++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL drain: got %0d pending responses, want 0", sb.size());
        end
    endtask

    task automatic test_errors();
        logic [4:0] bad [3];
        bad[0] = 5'd0; bad[1] = 5'd9; bad[2] = 5'd31;
        for (int i = 0; i < 3; i++) begin
            cmd_channel[0] = bad[i];
            cmd_valid[0] = 1'b1;
            tests++;
            if (cmd_ready[0] !== 1'b1) begin
                fails++; $display("FAIL err_ready: ch=%0d got %b, want 1", bad[i], cmd_ready[0]);
            end
            @(negedge clk);
            cmd_valid[0] = 1'b0;
            tests++;
            if (cmd_err[0] !== 1'b1) begin
                fails++; $display("FAIL err_pulse: ch=%0d got %b, want 1", bad[i], cmd_err[0]);
            end
            tests++;
            if (convst[0] !== 1'b0 || cmd_ready[0] !== 1'b1) begin
                fails++; $display("FAIL err_noframe: ch=%0d got cv=%b rdy=%b, want 0 1", bad[i], convst[0], cmd_ready[0]);
            end
            @(negedge clk);
            tests++;
            if (cmd_err[0] !== 1'b0) begin
                fails++; $display("FAIL err_width: ch=%0d got %b, want 0", bad[i], cmd_err[0]);
            end
        end
        send(0, 5'd2);
    endtask

    task automatic test_sck();
        for (int g = 0; g < 2; g++) begin
            val[g][0] = 12'h800;
            val[g][1] = 12'h001;
            send(g, 5'd1);
            send(g, 5'd2);
            send(g, 5'd1);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        cmd_channel[0] = 5'd5;
        cmd_valid[0] = 1'b1;
        k = 0;
        while (cmd_ready[0] !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        cur_ch[0] = 5'd5;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        repeat (99) @(negedge clk);
        tests++;
        if (nrise[0] != 5) begin
            fails++; $display("FAIL mid_shift: got %0d rises at T+100, want 5", nrise[0]);
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({convst[0], sck[0], sdi[0], rsp_valid[0], cmd_err[0], cmd_ready[0]} !== 6'b000001 ||
            rsp_channel[0] !== 5'd0 || rsp_data[0] !== 12'd0) begin
            fails++;
            $display("FAIL async_reset: got cv/sck/sdi/rsp/err/rdy=%b ch=%0d d=%h, want 000001 0 000",
                     {convst[0], sck[0], sdi[0], rsp_valid[0], cmd_err[0], cmd_ready[0]}, rsp_channel[0], rsp_data[0]);
        end
        pv[0] = 1'b0; pv[1] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(0, 5'd3);
        send(0, 5'd6);
    endtask

    initial begin
        cmd_valid = '0; cmd_sop = 1'b0; cmd_eop = 1'b0; sdo = '0;
        for (int g = 0; g < 2; g++) begin
            cmd_channel[g] = '0; pv[g] = 1'b0; pch[g] = '0; cur_ch[g] = 5'd1; nrise[g] = 0;
            for (int c = 0; c < 8; c++) val[g][c] = 12'(c * 273 + 90 + g);
        end
        fork
            monitor(0);
            monitor(1);
        join_none
        test_reset();
        test_pipeline();
        test_continuous();
        test_errors();
        test_sck();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
